// File: rtl/ll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ll_pkg
// Purpose  : Shared constants and walker state encoding for the linked-list
//            pointer walker.
// Revision : 1.0 - initial release
// ============================================================================
package ll_pkg;

    // Node id 0 terminates every chain
    localparam int NULL_PTR = 0;

    // Default sizing
    localparam int DEF_N   = 16;
    localparam int DEF_LAT = 2;

    // Walker states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2
    } walk_state_t;

endpackage : ll_pkg
`default_nettype wire

// File: rtl/ll_lat_mem.sv
`default_nettype none
// ============================================================================
// Module   : ll_lat_mem
// Purpose  : 1W/1R next-pointer table. Writes land in one cycle; a read
//            issued in cycle c returns data with rd_vld in cycle c+LAT.
// Revision : 1.0 - initial release
// ============================================================================
module ll_lat_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 4,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    input  logic [W-1:0] rd_addr,
    output logic [W-1:0] rd_data,
    output logic         rd_vld
);

    logic [W-1:0]   r_mem  [DEPTH];
    logic [W-1:0]   r_pipe [LAT];
    logic [LAT-1:0] r_vld;

    // Table storage; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read data pipeline: first stage samples the array, later stages delay
    always_ff @(posedge clk) begin
        r_pipe[0] <= r_mem[rd_addr];
        for (int k = 1; k < LAT; k++) begin
            r_pipe[k] <= r_pipe[k-1];
        end
    end

    // Read-valid pipeline; cleared on reset so an aborted read never resurfaces
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= rd_en;
            for (int k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign rd_data = r_pipe[LAT-1];
    assign rd_vld  = r_vld[LAT-1];

endmodule : ll_lat_mem
`default_nettype wire

// File: rtl/ll_walker.sv
`default_nettype none
// ============================================================================
// Module   : ll_walker
// Purpose  : Walks a linked list held in a next-pointer table, emitting each
//            node over a back-pressured stream with a last flag. Includes a
//            runtime table write port and a hop-limit loop guard.
// Revision : 1.0 - initial release
// ============================================================================
module ll_walker
    import ll_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int PTR_W    = $clog2(N),
    parameter int LAT      = DEF_LAT,
    parameter int MAX_HOPS = N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [PTR_W-1:0] wr_data,
    output logic             wr_rdy,
    input  logic             start_vld,
    input  logic [PTR_W-1:0] start_ptr,
    output logic             start_rdy,
    output logic             out_vld,
    output logic [PTR_W-1:0] out_ptr,
    output logic             out_last,
    input  logic             out_rdy,
    output logic             busy,
    output logic             err
);

    localparam int HOP_W = $clog2(MAX_HOPS + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t             c_null    = ptr_t'(NULL_PTR);
    localparam logic [HOP_W-1:0] c_hop_max = HOP_W'(MAX_HOPS);

    walk_state_t      r_state;
    walk_state_t      w_state_nxt;
    ptr_t             r_cur;
    ptr_t             r_nxt;
    logic [HOP_W-1:0] r_hop;
    logic             r_err;
    logic             w_last;
    logic             w_hop_max;
    logic             w_rd_en;
    ptr_t             w_rd_addr;
    ptr_t             w_rd_data;
    logic             w_rd_vld;

    assign w_hop_max = (r_hop == c_hop_max);
    assign w_last    = (r_nxt == c_null) | w_hop_max;
    assign busy      = (r_state != S_IDLE);
    assign out_ptr   = r_cur;
    assign err       = r_err;

    ll_lat_mem #(
        .DEPTH (N),
        .W     (PTR_W),
        .LAT   (LAT)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en & wr_rdy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data),
        .rd_vld  (w_rd_vld)
    );

    // Next-state, handshake readies, stream outputs and table read issue
    always_comb begin
        w_state_nxt = r_state;
        wr_rdy      = 1'b0;
        start_rdy   = 1'b0;
        out_vld     = 1'b0;
        out_last    = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_addr   = start_ptr;
        case (r_state)
            S_IDLE: begin
                wr_rdy    = 1'b1;
                start_rdy = ~wr_en;               // a same-cycle write wins
                if (start_vld && !wr_en && (start_ptr != c_null)) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_rd_vld) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                out_vld  = 1'b1;
                out_last = w_last;
                if (out_rdy) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_rd_en     = 1'b1;
                        w_rd_addr   = r_nxt;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, current/next node, hop count and loop-guard error pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cur   <= c_null;
            r_nxt   <= c_null;
            r_hop   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_vld && !wr_en && (start_ptr != c_null)) begin
                        r_cur <= start_ptr;
                        r_hop <= HOP_W'(1);
                    end
                end
                S_FETCH: begin
                    if (w_rd_vld) begin
                        r_nxt <= w_rd_data;
                    end
                end
                S_EMIT: begin
                    if (out_rdy) begin
                        // Hop limit reached with more list left: cyclic or too long
                        r_err <= w_hop_max & (r_nxt != c_null);
                        if (!w_last) begin
                            r_cur <= r_nxt;
                            r_hop <= r_hop + HOP_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : ll_walker
`default_nettype wire
